// File: rtl/avalon_st_mult_pkg.sv
// Shared definitions for the serialized 32x32 multiply link (master and slave ends).
package avalon_st_mult_pkg;

    localparam int SZ_DEF        = 32;
    localparam int DSZ_DEF       = 8;
    localparam int ASZ_DEF       = 2;
    localparam int REQ_BEATS_DEF = ASZ_DEF * SZ_DEF / DSZ_DEF;
    localparam int RSP_BEATS_DEF = 2 * SZ_DEF / DSZ_DEF;
    localparam int CNT_W         = $clog2(8);

    typedef enum logic [1:0] {
        LOAD,
        SEND,
        RECV
    } state_e;

endpackage

// File: rtl/avalon_st_mult_master.sv
// Requester end of the serialized multiply link: latches {B,A}, streams it as an
// 8-beat Avalon-ST request and collects the 8-beat product packet into RES.
module avalon_st_mult_master
    import avalon_st_mult_pkg::*;
#(
    parameter int SZ  = SZ_DEF,
    parameter int DSZ = DSZ_DEF,
    parameter int ASZ = ASZ_DEF
) (
    input  logic            clk,
    input  logic            _rst,
    output logic            out_clk,
    input  logic [SZ-1:0]   A,
    input  logic [SZ-1:0]   B,
    output logic [2*SZ-1:0] RES,
    output logic [DSZ-1:0]  data_out,
    output logic            valid_out,
    output logic            startofpacket_out,
    output logic            endofpacket_out,
    input  logic            ready_in,
    input  logic [DSZ-1:0]  data_in,
    input  logic            valid_in,
    input  logic            startofpacket_in,
    input  logic            endofpacket_in,
    output logic            ready_out
);

    localparam int REQ_BEATS = ASZ * SZ / DSZ;
    localparam int RSP_BEATS = 2 * SZ / DSZ;
    // One extra bit so the response index can reach RSP_BEATS and mark overflow.
    localparam int RW = CNT_W + 1;

    state_e          state_q, state_d;
    logic [2*SZ-1:0] req_q, req_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [RW-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic [2*SZ-1:0] rsp_q, rsp_d;
    logic [2*SZ-1:0] res_q, res_d;
    logic            req_xfer;
    logic            rsp_xfer;
    logic [RW-1:0]   rsp_idx;

    assign out_clk = clk;

    // Request outputs come straight from state and the shift register, so they
    // are naturally held while ready_in is low and are zero outside SEND.
    assign valid_out         = (state_q == SEND);
    assign data_out          = valid_out ? req_q[DSZ-1:0] : '0;
    assign startofpacket_out = valid_out && (req_cnt_q == '0);
    assign endofpacket_out   = valid_out && (req_cnt_q == CNT_W'(REQ_BEATS - 1));
    assign ready_out         = (state_q == RECV);
    assign RES               = res_q;

    assign req_xfer = valid_out && ready_in;
    assign rsp_xfer = ready_out && valid_in;
    // SOP restarts assembly regardless of how many beats came before it.
    assign rsp_idx  = startofpacket_in ? '0 : rsp_cnt_q;

    // Next-state and datapath update for LOAD -> SEND -> RECV -> LOAD.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        rsp_d     = rsp_q;
        res_d     = res_q;
        case (state_q)
            LOAD: begin
                req_d     = {B, A};
                req_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (req_xfer) begin
                    req_d = req_q >> DSZ;
                    if (req_cnt_q == CNT_W'(REQ_BEATS - 1)) begin
                        req_cnt_d = '0;
                        rsp_cnt_d = '0;
                        state_d   = RECV;
                    end else begin
                        req_cnt_d = req_cnt_q + 1'b1;
                    end
                end
            end
            RECV: begin
                if (rsp_xfer) begin
                    // LSB-first bytes shift in from the top; after exactly
                    // RSP_BEATS beats since SOP byte 0 sits at the bottom.
                    if (rsp_idx < RW'(RSP_BEATS)) begin
                        rsp_d     = {data_in, rsp_q[2*SZ-1:DSZ]};
                        rsp_cnt_d = rsp_idx + 1'b1;
                    end
                    if (endofpacket_in) begin
                        if (rsp_idx == RW'(RSP_BEATS - 1)) begin
                            res_d = rsp_d;
                        end
                        rsp_cnt_d = '0;
                        state_d   = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Control state and result register, synchronously reset.
    always_ff @(posedge clk) begin
        if (_rst) begin
            state_q   <= LOAD;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            res_q     <= res_d;
        end
    end

    // Serializer/deserializer shift registers; their contents are only observed
    // through state-gated outputs, so they need no reset.
    always_ff @(posedge clk) begin
        req_q <= req_d;
        rsp_q <= rsp_d;
    end

endmodule

// File: tb/tb_avalon_st_mult_master.sv
// Bench for avalon_st_mult_master: behavioural endpoint plus queue scoreboard.
module tb_avalon_st_mult_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_clk;
    logic [31:0] A, B;
    logic [63:0] RES;
    logic [7:0]  data_out;
    logic        valid_out, startofpacket_out, endofpacket_out;
    logic        ready_in;
    logic [7:0]  data_in;
    logic        valid_in, startofpacket_in, endofpacket_in;
    logic        ready_out;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    beat_t       exp_req[$];
    logic [63:0] exp_res[$];
    bit          short_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit tgl_mode = 1'b0;
    bit first_res = 1'b1;

    // Directed vectors; products are worked out by hand.
    logic [31:0] va[8] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd5, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0100};
    logic [31:0] vb[8] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'h0001_0000, 32'd2, 32'd3};
    logic [63:0] vr[8] = '{64'd2, 64'd2, 64'hFFFF_FFFE_0000_0001, 64'd21, 64'd35,
                           64'd35, 64'h0000_0001_FFFF_FFFE, 64'h0000_0000_0000_0300};
    bit          vs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit          vt[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    avalon_st_mult_master dut (
        .clk               (clk),
        ._rst              (rst),
        .out_clk           (out_clk),
        .A                 (A),
        .B                 (B),
        .RES               (RES),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .ready_in          (ready_in),
        .data_in           (data_in),
        .valid_in          (valid_in),
        .startofpacket_in  (startofpacket_in),
        .endofpacket_in    (endofpacket_in),
        .ready_out         (ready_out)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_vec(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] res, input bit shrt);
        logic [63:0] w;
        beat_t bt;
        w = {b, a};
        for (int i = 0; i < 8; i++) begin
            bt.d = w[8*i +: 8];
            bt.s = (i == 0);
            bt.e = (i == 7);
            exp_req.push_back(bt);
        end
        exp_res.push_back(res);
        short_q.push_back(shrt);
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    task automatic wait_sop();
        bit seen;
        seen = 1'b0;
        while (!seen) begin
            @(negedge clk);
            seen = valid_out && ready_in && startofpacket_out;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_out"}, valid_out, 1'b0);
        check({tag, "_data_out"}, data_out, 8'h00);
        check({tag, "_sop_out"}, startofpacket_out, 1'b0);
        check({tag, "_eop_out"}, endofpacket_out, 1'b0);
        check({tag, "_ready_out"}, ready_out, 1'b0);
        check({tag, "_RES"}, RES, 64'd0);
    endtask

    // Endpoint model: receives the request, multiplies, returns the product LSB-first.
    initial begin
        logic [63:0] rxw, prod;
        int          rxn, txn, txlen;
        bit          tx_act, rq, rs, shrt;
        logic [7:0]  rd;
        logic        reop;
        rxw = '0; prod = '0; rxn = 0; txn = 0; txlen = 8; tx_act = 1'b0;
        valid_in = 1'b0; data_in = 8'h00; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
        ready_in = 1'b1;
        forever begin
            @(negedge clk);
            rq   = valid_out && ready_in;
            rd   = data_out;
            reop = endofpacket_out;
            rs   = valid_in && ready_out;
            @(posedge clk);
            #1;
            if (rst) begin
                rxn = 0; txn = 0; tx_act = 1'b0;
                ready_in = 1'b1;
            end else begin
                if (rs) begin
                    txn++;
                    if (txn == txlen) tx_act = 1'b0;
                end
                if (rq) begin
                    rxw[8*rxn +: 8] = rd;
                    rxn++;
                    if (reop) begin
                        prod = {32'd0, rxw[31:0]} * {32'd0, rxw[63:32]};
                        shrt = 1'b0;
                        if (short_q.size() > 0) shrt = short_q.pop_front();
                        txlen  = shrt ? 4 : 8;
                        txn    = 0;
                        tx_act = 1'b1;
                        rxn    = 0;
                    end
                end
                ready_in = tgl_mode ? ~ready_in : 1'b1;
            end
            if (tx_act) begin
                valid_in         = 1'b1;
                data_in          = prod[8*txn +: 8];
                startofpacket_in = (txn == 0);
                endofpacket_in   = (txn == txlen - 1);
            end else begin
                valid_in         = 1'b0;
                data_in          = 8'h00;
                startofpacket_in = 1'b0;
                endofpacket_in   = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request beat or a result.
    initial begin
        bit          hold, pend;
        beat_t       ph, bt;
        logic [63:0] er;
        hold = 1'b0; pend = 1'b0; ph = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (exp_res.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got %h expected none", RES);
                    end else begin
                        er = exp_res.pop_front();
                        check("RES", RES, er);
                        if (first_res) begin
                            first_res = 1'b0;
                            check("RES_first_cycle", 64'(cyc), 64'd18);
                        end
                    end
                end
                if (hold) begin
                    check("hold_valid", valid_out, 1'b1);
                    check("hold_data", data_out, ph.d);
                    check("hold_sop", startofpacket_out, ph.s);
                    check("hold_eop", endofpacket_out, ph.e);
                end
                hold = valid_out && !ready_in;
                ph.d = data_out;
                ph.s = startofpacket_out;
                ph.e = endofpacket_out;
                if (valid_out && ready_in) begin
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got %h expected none", data_out);
                    end else begin
                        bt = exp_req.pop_front();
                        check("req_data", data_out, bt.d);
                        check("req_sop", startofpacket_out, bt.s);
                        check("req_eop", endofpacket_out, bt.e);
                    end
                end
                if (valid_in && ready_out && endofpacket_in) pend = 1'b1;
            end
        end
    end

    // Stimulus: operand vectors applied mid-SEND, then a reset pulse during beat 4.
    initial begin
        int n;
        rst = 1'b1;
        A = va[0];
        B = vb[0];
        push_vec(va[0], vb[0], vr[0], vs[0]);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc = 1;
        for (int k = 1; k < 8; k++) begin
            wait_sop();
            A = va[k];
            B = vb[k];
            tgl_mode = vt[k];
            push_vec(va[k], vb[k], vr[k], vs[k]);
        end
        wait_sop();
        n = 1;
        while (n < 4) begin
            @(negedge clk);
            if (valid_out && ready_in) n++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_req.delete();
        exp_res.delete();
        short_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_vec(va[7], vb[7], vr[7], 1'b0);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        while (exp_res.size() != 0) @(posedge clk);
        check("req_queue_drained", 64'(exp_req.size()), 64'd0);
        summary();
        $finish;
    end

    initial begin
        #50000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion, %0d results pending", exp_res.size());
        summary();
        $finish;
    end

endmodule

// File: doc/avalon_st_mult_master.md
Name: avalon_st_mult_master

Overview:
Requester side of a serialized 32x32 multiply link over Avalon-ST. Latches operands A and B and streams them as one 8-beat, 8-bit request packet to a multiplier endpoint. Receives the 8-beat product packet back and presents the 64-bit result on RES. Forwards its clock to the endpoint as out_clk so both ends share one clock domain.

Parameters:
SZ, 32, operand width in bits; must be a multiple of DSZ.
DSZ, 8, Avalon-ST symbol/data width per beat.
ASZ, 2, operands per request packet.
Derived: REQ_BEATS = ASZ*SZ/DSZ = 8; RSP_BEATS = 2*SZ/DSZ = 8.

Ports:
clk  in  1  system clock; all logic on rising edge.
_rst  in  1  reset, synchronous, active-high.
out_clk  out  1  clock forwarded to endpoint; combinational copy of clk.
A  in  SZ  multiplicand.
B  in  SZ  multiplier.
RES  out  2*SZ  last completed product.
data_out  out  DSZ  request beat data.
valid_out  out  1  request beat valid.
startofpacket_out  out  1  first request beat.
endofpacket_out  out  1  last request beat.
ready_in  in  1  endpoint accepts request beat; ready latency 0.
data_in  in  DSZ  response beat data.
valid_in  in  1  response beat valid.
startofpacket_in  in  1  first response beat.
endofpacket_in  in  1  last response beat.
ready_out  out  1  block accepts response beat; ready latency 0.

Behaviour:
- Reset (_rst=1 at clock edge): state LOAD; RES=0, data_out=0, valid_out=0, sop/eop_out=0, ready_out=0; beat counters=0.
- A beat transfers on a clock edge where valid && ready (both directions).
- FSM LOAD -> SEND -> RECV -> LOAD, repeating forever with no idle gap.
- LOAD (1 cycle): register {B,A} into a 2*SZ shift register; go to SEND.
- SEND: valid_out=1. data_out is byte k of {B,A}, LSB first: A[7:0], A[15:8], ..., then B[7:0], and so on. startofpacket_out=1 only for k=0; endofpacket_out=1 only for k=REQ_BEATS-1. While ready_in=0, outputs hold stable. After the last beat transfers: valid_out=0 and go to RECV.
- RECV: ready_out=1. Each accepted beat writes byte j of a response buffer, LSB first.
  - startofpacket_in forces j=0.
  - Beats beyond RSP_BEATS are dropped until EOP.
  - Accepted beat with endofpacket_in:
    - If j==RSP_BEATS-1, RES <= assembled value on that edge, then go to LOAD.
    - If the packet is short, RES is unchanged and the block still goes to LOAD.
  - ready_out=0 and valid_in ignored outside RECV.
- A/B changes during SEND/RECV do not affect the in-flight packet; they are sampled at the next LOAD.
- Reset asserted mid-packet aborts immediately to reset values. No partial RES update.
- Latency with ready_in=1 and an endpoint answering on the cycle after the request EOP:
  - LOAD at cycle 1; request beats on cycles 2-9.
  - Response beats on cycles 10-17; RES valid from cycle 18.
  - Transaction period 17 cycles.
- Product width: RES = A*B unsigned, full 2*SZ bits, no truncation.

Decomposition:
- Shared package avalon_st_mult_pkg:
  - SZ/DSZ/ASZ defaults and derived REQ_BEATS/RSP_BEATS localparams.
  - State enum {LOAD, SEND, RECV}.
  - Beat-counter width $clog2(8).
- Peer endpoint avalon_st_mult_slave (separate block, same package) mirrors the protocol:
  - Sink: ready_out=1 while idle; deserializes 8 bytes LSB-first into A, B.
  - Computes A*B in 1 cycle.
  - Source: sends 8 product bytes LSB-first with SOP/EOP.
- No sub-module inside the master. Serializer and deserializer are inline counters plus shift registers.

Test Plan:
- Reset held 4 cycles, then A=1, B=2, ready always 1, paired with avalon_st_mult_slave -> request bytes 01,00,00,00,02,00,00,00 with SOP on beat 0 and EOP on beat 7; RES=2 at cycle 18; RES stays 2 on repeated transactions.
- A=0xFFFF_FFFF, B=0xFFFF_FFFF -> RES=0xFFFF_FFFE_0000_0001 (no truncation).
- ready_in toggled 1-0-1 every cycle -> data_out/sop/eop held stable while ready_in=0; the same 8 bytes are delivered; RES correct.
- Change A from 3 to 5 mid-SEND with B=7 -> current RES=21; next transaction RES=35.
- Model sends a response packet with EOP on beat 3 -> RES unchanged; block returns to LOAD and reissues the request.
- _rst pulsed during beat 4 of SEND -> all outputs return to reset values on the next edge; RES=0; a new packet starts with SOP after release.
